// File: rtl/video_raster_pkg.sv
// video_raster_pkg: default raster timing and shared types for video_raster_gen
package video_raster_pkg;
   localparam logic [8:0] DEF_H_TOTAL   = 9'd384;
   localparam logic [8:0] DEF_V_TOTAL   = 9'd312;
   localparam logic [8:0] DEF_H_ACT     = 9'd128;
   localparam logic [8:0] DEF_V_ACT     = 9'd192;
   localparam logic [8:0] DEF_HBL_S     = 9'd28;
   localparam logic [8:0] DEF_HS_S      = 9'd44;
   localparam logic [8:0] DEF_HS_E      = 9'd76;
   localparam logic [8:0] DEF_HBL_E     = 9'd108;
   localparam logic [8:0] DEF_VBL_S     = 9'd236;
   localparam logic [8:0] DEF_VBL_SH    = 9'd24;
   localparam logic [8:0] DEF_VS_S      = 9'd240;
   localparam logic [8:0] DEF_VS_E      = 9'd244;
   localparam logic [8:0] DEF_VBL_E     = 9'd260;
   localparam logic [8:0] DEF_VBL_EH    = 9'd104;
   localparam logic [8:0] DEF_INT_S     = 9'd4;
   localparam logic [8:0] DEF_INT_E     = 9'd132;
   localparam logic [8:0] DEF_INT_FRAME = 9'd244;
   localparam int         DEF_N_LINT    = 2;
   localparam int         DEF_FLASH_W   = 5;
   typedef struct packed {
      logic [8:0] hc;
      logic [8:0] vc;
   } raster_pos_t;
   typedef logic [7:0] line_no_t;
endpackage

// File: rtl/video_raster_gen_if.sv
// video_raster_gen_if: CPU-side controls and pixel-datapath timing outputs of video_raster_gen
interface video_raster_gen_if
   import video_raster_pkg::*;
#(
   parameter int N_LINT  = DEF_N_LINT,
   parameter int FLASH_W = DEF_FLASH_W
) ();
   logic                ce_6mp, ce_6mn, soff;
   logic [1:0]          mode;
   line_no_t [N_LINT-1:0] line_no;
   logic [N_LINT-1:0]   lint_clr, int_line, lint_stat;
   logic [8:0]          hc, vc;
   logic                hblank, hsync, vblank, vsync, fetch, io_cont, mem_cont, int_frame;
   logic [4:0]          col;
   logic [FLASH_W-1:0]  flashcnt;
   logic [7:0]          lpen, hpen;
   modport master (
      input  ce_6mp, ce_6mn, soff, mode, line_no, lint_clr,
      output hc, vc, hblank, hsync, vblank, vsync, fetch, col, io_cont, mem_cont,
             int_line, int_frame, lint_stat, flashcnt, lpen, hpen
   );
   modport slave (
      output ce_6mp, ce_6mn, soff, mode, line_no, lint_clr,
      input  hc, vc, hblank, hsync, vblank, vsync, fetch, col, io_cont, mem_cont,
             int_line, int_frame, lint_stat, flashcnt, lpen, hpen
   );
endinterface

// File: rtl/video_line_int.sv
// video_line_int: one line-interrupt channel (compare at INT_S, pulse until INT_E, sticky status)
module video_line_int
   import video_raster_pkg::*;
#(
   parameter logic [8:0] INT_S = DEF_INT_S,
   parameter logic [8:0] INT_E = DEF_INT_E,
   parameter logic [8:0] V_ACT = DEF_V_ACT
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ce,
   input  raster_pos_t pos,
   input  line_no_t    line_no,
   input  logic        clr,
   output logic        int_line,
   output logic        lint_stat
);
   logic hit;
   // line_no only matters at INT_S, so mid-line writes land on the next line
   assign hit = ce && pos.hc == INT_S && pos.vc == {1'b0, line_no} && {1'b0, line_no} < V_ACT;
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         int_line  <= 1'b0;
         lint_stat <= 1'b0;
      end else begin
         int_line  <= hit ? 1'b1 : (ce && pos.hc == INT_E) ? 1'b0 : int_line;
         lint_stat <= hit ? 1'b1 : clr ? 1'b0 : lint_stat;
      end
endmodule

// File: rtl/video_raster_gen.sv
// video_raster_gen: raster counters, blank/sync/fetch timing, contention strobes, frame/line interrupts
// Light-pen latches are built only when VIDEO_RASTER_LPEN_EN is defined.
module video_raster_gen
   import video_raster_pkg::*;
#(
   parameter logic [8:0] H_TOTAL   = DEF_H_TOTAL,
   parameter logic [8:0] V_TOTAL   = DEF_V_TOTAL,
   parameter logic [8:0] H_ACT     = DEF_H_ACT,
   parameter logic [8:0] V_ACT     = DEF_V_ACT,
   parameter logic [8:0] HBL_S     = DEF_HBL_S,
   parameter logic [8:0] HS_S      = DEF_HS_S,
   parameter logic [8:0] HS_E      = DEF_HS_E,
   parameter logic [8:0] HBL_E     = DEF_HBL_E,
   parameter logic [8:0] VBL_S     = DEF_VBL_S,
   parameter logic [8:0] VBL_SH    = DEF_VBL_SH,
   parameter logic [8:0] VS_S      = DEF_VS_S,
   parameter logic [8:0] VS_E      = DEF_VS_E,
   parameter logic [8:0] VBL_E     = DEF_VBL_E,
   parameter logic [8:0] VBL_EH    = DEF_VBL_EH,
   parameter logic [8:0] INT_S     = DEF_INT_S,
   parameter logic [8:0] INT_E     = DEF_INT_E,
   parameter logic [8:0] INT_FRAME = DEF_INT_FRAME,
   parameter int         N_LINT    = DEF_N_LINT,
   parameter int         FLASH_W   = DEF_FLASH_W
) (
   input logic clk_sys,
   input logic reset_n,
   video_raster_gen_if.master bus
);
   raster_pos_t        pos;
   logic [FLASH_W-1:0] flash;
   logic               hbl, hs, vbl, vs, fe, ifr, h_end, v_end, io_cont;
   logic [4:0]         col;
   logic [N_LINT-1:0]  il, ls;
   assign h_end   = pos.hc == H_TOTAL - 9'd1;
   assign v_end   = pos.vc == V_TOTAL - 9'd1;
   assign col     = {~pos.hc[7], pos.hc[6:3]};
   assign io_cont = ~&pos.hc[2:0];
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         pos   <= '0;
         flash <= '0;
      end else if (bus.ce_6mp) begin
         pos.hc <= h_end ? 9'd0 : pos.hc + 9'd1;
         pos.vc <= !h_end ? pos.vc : v_end ? 9'd0 : pos.vc + 9'd1;
         flash  <= (h_end && v_end) ? flash + FLASH_W'(1) : flash;
      end
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         {hbl, hs, vbl, vs, fe, ifr} <= '0;
      end else if (bus.ce_6mn) begin
         hbl <= (pos.hc == HBL_S) ? 1'b1 : (pos.hc == HBL_E) ? 1'b0 : hbl;
         hs  <= (pos.hc == HS_S) ? 1'b1 : (pos.hc == HS_E) ? 1'b0 : hs;
         vbl <= (pos.vc == VBL_S && pos.hc == VBL_SH) ? 1'b1 :
                (pos.vc == VBL_E && pos.hc == VBL_EH) ? 1'b0 : vbl;
         vs  <= (pos.vc == VS_S) ? 1'b1 : (pos.vc == VS_E) ? 1'b0 : vs;
         fe  <= (pos.hc == 9'd0) ? 1'b0 :
                (pos.hc >= H_ACT && pos.vc < V_ACT && pos.hc[2:0] == 3'd0) ? ~bus.soff : fe;
         ifr <= (pos.vc == INT_FRAME && pos.hc == INT_S) ? 1'b1 : (pos.hc == INT_E) ? 1'b0 : ifr;
      end
   for (genvar i = 0; i < N_LINT; i++) begin : g_lint
      video_line_int #(.INT_S(INT_S), .INT_E(INT_E), .V_ACT(V_ACT)) u_lint (
         .clk_sys   (clk_sys),
         .reset_n   (reset_n),
         .ce        (bus.ce_6mn),
         .pos       (pos),
         .line_no   (bus.line_no[i]),
         .clr       (bus.lint_clr[i]),
         .int_line  (il[i]),
         .lint_stat (ls[i])
      );
   end
`ifdef VIDEO_RASTER_LPEN_EN
   logic [7:0] lp, hp;
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         lp <= 8'd0;
         hp <= V_ACT[7:0];
      end else if (bus.ce_6mn && !io_cont) begin
         lp <= fe ? {col, 3'b000} : 8'd0;
         hp <= (bus.soff || pos.vc >= V_ACT) ? V_ACT[7:0] : pos.vc[7:0];
      end
   assign bus.lpen = lp;
   assign bus.hpen = hp;
`else
   assign bus.lpen = 8'd0;
   assign bus.hpen = V_ACT[7:0];
`endif
   assign bus.hc        = pos.hc;
   assign bus.vc        = pos.vc;
   assign bus.hblank    = hbl;
   assign bus.hsync     = hs;
   assign bus.vblank    = vbl;
   assign bus.vsync     = vs;
   assign bus.fetch     = fe;
   assign bus.col       = col;
   assign bus.io_cont   = io_cont;
   assign bus.mem_cont  = (fe || (bus.mode == 2'd0 && pos.hc[6])) ? ~&pos.hc[2:0] : ~&pos.hc[1:0];
   assign bus.int_line  = il;
   assign bus.int_frame = ifr;
   assign bus.lint_stat = ls;
   assign bus.flashcnt  = flash;
endmodule

// File: tb/tb_video_raster_gen.sv
// tb_video_raster_gen: directed raster run with an interrupt/flash event scoreboard
// Lines are shortened to 160 pixels so a whole frame plus the reset scenario fits the cycle budget.
module tb_video_raster_gen;
   import video_raster_pkg::*;
   localparam logic [8:0] HT = 9'd160;
`ifdef VIDEO_RASTER_LPEN_EN
   localparam int LPEN20 = 8, HPEN20 = 20;
`else
   localparam int LPEN20 = 0, HPEN20 = 192;
`endif
   typedef struct {
      int hc, vc, il, ifr, ls, fl;
   } ev_t;
   logic clk_sys = 1'b0;
   logic reset_n = 1'b1;
   int   errors = 0, checks = 0;
   bit   abort = 1'b0;
   ev_t  q[$];
   video_raster_gen_if #(.N_LINT(2), .FLASH_W(5)) vif ();
   video_raster_gen #(.H_TOTAL(HT)) dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(vif));
   always #5 clk_sys = ~clk_sys;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask
   task automatic wait_pos(input int h, input int v);
      if (abort) return;
      for (int n = 0; n < 60000; n++) begin
         @(negedge clk_sys);
         if (int'(vif.hc) == h && int'(vif.vc) == v) return;
      end
      abort = 1'b1;
      checks++;
      errors++;
      $display("FAIL wait_pos: hc=%0d vc=%0d never reached", h, v);
   endtask
   function automatic void push(input int hc, input int vc, input int il, input int ifr, input int ls, input int fl);
      q.push_back('{hc, vc, il, ifr, ls, fl});
   endfunction
   function automatic int obs();
      return int'({vif.int_line, vif.int_frame, vif.lint_stat, vif.flashcnt});
   endfunction
   // Monitor: every change of the interrupt/flash outputs consumes one expected event
   initial begin : monitor
      int  prev, cur, k;
      ev_t e;
      k = 0;
      repeat (2) @(negedge clk_sys);
      prev = obs();
      forever begin
         @(negedge clk_sys);
         cur = obs();
         if (cur != prev) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ev_unexpected: hc=%0d vc=%0d int_line=%0d int_frame=%0d lint_stat=%0d flashcnt=%0d",
                        vif.hc, vif.vc, vif.int_line, vif.int_frame, vif.lint_stat, vif.flashcnt);
            end else begin
               e = q.pop_front();
               chk($sformatf("ev%0d_hc", k), int'(vif.hc), e.hc);
               chk($sformatf("ev%0d_vc", k), int'(vif.vc), e.vc);
               chk($sformatf("ev%0d_int_line", k), int'(vif.int_line), e.il);
               chk($sformatf("ev%0d_int_frame", k), int'(vif.int_frame), e.ifr);
               chk($sformatf("ev%0d_lint_stat", k), int'(vif.lint_stat), e.ls);
               chk($sformatf("ev%0d_flashcnt", k), int'(vif.flashcnt), e.fl);
            end
            k++;
            prev = cur;
         end
      end
   end
   initial begin
      vif.ce_6mp   = 1'b1;
      vif.ce_6mn   = 1'b1;
      vif.soff     = 1'b0;
      vif.mode     = 2'd1;
      vif.line_no  = {8'd10, 8'd10};
      vif.lint_clr = 2'b00;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      chk("rst_hc", int'(vif.hc), 0);
      chk("rst_vc", int'(vif.vc), 0);
      chk("rst_flags", int'({vif.hblank, vif.hsync, vif.vblank, vif.vsync}), 0);
      chk("rst_fetch", int'(vif.fetch), 0);
      chk("rst_ints", int'({vif.int_line, vif.int_frame, vif.lint_stat}), 0);
      chk("rst_flashcnt", int'(vif.flashcnt), 0);
      chk("rst_lpen", int'(vif.lpen), 0);
      chk("rst_hpen", int'(vif.hpen), 192);
      // both channels on line 10; outputs are registered, so seen one pixel later
      push(5, 10, 3, 0, 3, 0);
      push(133, 10, 0, 0, 3, 0);
      reset_n = 1'b1;
      wait_pos(4, 10);
      vif.lint_clr = 2'b01;
      @(negedge clk_sys);
      vif.lint_clr = 2'b00;
      wait_pos(140, 10);
      vif.line_no[0] = 8'd200;
      wait_pos(30, 20);
      chk("hblank_on", int'(vif.hblank), 1);
      chk("hsync_pre", int'(vif.hsync), 0);
      wait_pos(50, 20);
      chk("hsync_on", int'(vif.hsync), 1);
      wait_pos(80, 20);
      chk("hsync_off", int'(vif.hsync), 0);
      chk("hblank_mid", int'(vif.hblank), 1);
      wait_pos(110, 20);
      chk("hblank_off", int'(vif.hblank), 0);
      wait_pos(129, 20);
      chk("fetch_on", int'(vif.fetch), 1);
      wait_pos(139, 20);
      chk("col_139", int'(vif.col), 1);
      chk("io_cont_139", int'(vif.io_cont), 1);
      chk("mem_cont_fetch_139", int'(vif.mem_cont), 1);
      wait_pos(143, 20);
      chk("io_cont_143", int'(vif.io_cont), 0);
      chk("mem_cont_143", int'(vif.mem_cont), 0);
      wait_pos(145, 20);
      chk("lpen_20", int'(vif.lpen), LPEN20);
      chk("hpen_20", int'(vif.hpen), HPEN20);
      wait_pos(0, 25);
      push(1, 25, 0, 0, 2, 0);
      push(5, 244, 0, 1, 2, 0);
      push(133, 244, 0, 0, 2, 0);
      push(0, 0, 0, 0, 2, 1);
      push(5, 10, 2, 0, 2, 1);
      push(133, 10, 0, 0, 2, 1);
      vif.lint_clr = 2'b01;
      @(negedge clk_sys);
      vif.lint_clr = 2'b00;
      wait_pos(0, 49);
      vif.soff = 1'b1;
      wait_pos(67, 50);
      chk("mem_cont_m1_67", int'(vif.mem_cont), 0);
      vif.mode = 2'd0;
      #1 chk("mem_cont_m0_67", int'(vif.mem_cont), 1);
      vif.mode = 2'd1;
      wait_pos(129, 50);
      chk("fetch_soff", int'(vif.fetch), 0);
      wait_pos(139, 50);
      chk("mem_cont_soff_139", int'(vif.mem_cont), 0);
      wait_pos(145, 50);
      chk("lpen_soff", int'(vif.lpen), 0);
      chk("hpen_soff", int'(vif.hpen), 192);
      wait_pos(0, 51);
      vif.soff = 1'b0;
      wait_pos(20, 236);
      chk("vblank_pre", int'(vif.vblank), 0);
      wait_pos(26, 236);
      chk("vblank_on", int'(vif.vblank), 1);
      wait_pos(10, 242);
      chk("vsync_on", int'(vif.vsync), 1);
      wait_pos(10, 250);
      chk("vsync_off", int'(vif.vsync), 0);
      chk("vblank_mid", int'(vif.vblank), 1);
      wait_pos(10, 261);
      chk("vblank_off", int'(vif.vblank), 0);
      wait_pos(159, 311);
      @(negedge clk_sys);
      chk("wrap_hc", int'(vif.hc), 0);
      chk("wrap_vc", int'(vif.vc), 0);
      chk("wrap_flashcnt", int'(vif.flashcnt), 1);
      wait_pos(150, 100);
      chk("pre_rst_fetch", int'(vif.fetch), 1);
      #2 reset_n = 1'b0;
      push(0, 0, 0, 0, 0, 0);
      #1;
      chk("arst_hc", int'(vif.hc), 0);
      chk("arst_vc", int'(vif.vc), 0);
      chk("arst_fetch", int'(vif.fetch), 0);
      chk("arst_lint_stat", int'(vif.lint_stat), 0);
      chk("arst_flashcnt", int'(vif.flashcnt), 0);
      chk("arst_hpen", int'(vif.hpen), 192);
      @(negedge clk_sys);
      @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      chk("restart_hc", int'(vif.hc), 3);
      chk("restart_vc", int'(vif.vc), 0);
      @(negedge clk_sys);
      chk("sb_pending", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
